div_req_ctrl: RTL and testbench

- Request front-end for the unsigned iterative `divider`: accepts RISC-V M-extension DIV/DIVU/REM/REMU requests over a valid/ready handshake.
- Converts signed operands to magnitudes and resolves divide-by-zero and signed overflow locally.
- Drives the divider's start/operand inputs and consumes its done/quotient/remainder.
- Returns the sign-corrected result over a registered valid/ready response port. Sits between the execute-stage issue logic and `divider`.

---
 rtl/div_req_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_div_req_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_req_ctrl.sv
// div_req_ctrl -- request front-end for the unsigned iterative divider.
//
// Accepts RISC-V DIV/DIVU/REM/REMU requests over a valid/ready handshake,
// turns signed operands into magnitudes for the unsigned divider, settles
// divide-by-zero and signed overflow locally, and returns the sign-corrected
// result on a registered valid/ready response port. One request in flight.
//
// Optional build macro: DIV_REQ_CACHE_EN adds a one-entry result cache that
// answers a repeated (a, b, signedness) request without using the divider.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   req_valid_i/req_ready_o  request handshake
//   req_op_i                 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_a_i, req_b_i         dividend, divisor
//   req_tag_i                tag echoed on the response
//   flush_i                  kills the in-flight request, blocks accept
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_data_o, rsp_tag_o    result and its tag
//   busy_o                   a request is being processed or drained
//   div_start_o              one-cycle start pulse to the divider
//   div_opr1_o, div_opr2_o   operand magnitudes to the divider
//   div_done_i, div_quo_i, div_rem_i  divider completion and results
module div_req_ctrl #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [XLEN-1:0]  req_a_i,
  input  logic [XLEN-1:0]  req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [XLEN-1:0]  rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             busy_o,
  output logic             div_start_o,
  output logic [XLEN-1:0]  div_opr1_o,
  output logic [XLEN-1:0]  div_opr2_o,
  input  logic             div_done_i,
  input  logic [XLEN-1:0]  div_quo_i,
  input  logic [XLEN-1:0]  div_rem_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t           state;
  logic             ready_q;     // registered "will be in IDLE", gated by flush below
  logic             rem_sel_q;   // op[1]: answer with remainder
  logic             neg_a_q;
  logic             neg_b_q;
  logic [TAG_W-1:0] tag_q;

  // Request decode.
  logic            sgn, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            b_zero, ovf, special;
  logic [XLEN-1:0] special_res;
  logic            accept;

  assign sgn   = ~req_op_i[0];
  assign neg_a = sgn & req_a_i[XLEN-1];
  assign neg_b = sgn & req_b_i[XLEN-1];
  // Negating MIN_NEG wraps back to MIN_NEG, which is its correct unsigned magnitude.
  assign mag_a = neg_a ? -req_a_i : req_a_i;
  assign mag_b = neg_b ? -req_b_i : req_b_i;

  // Divide-by-zero takes priority over overflow (b cannot be both 0 and -1).
  assign b_zero      = (req_b_i == '0);
  assign ovf         = sgn & (req_a_i == MIN_NEG) & (req_b_i == ALL_ONES);
  assign special     = b_zero | ovf;
  assign special_res = b_zero ? (req_op_i[1] ? req_a_i : ALL_ONES)
                              : (req_op_i[1] ? '0      : MIN_NEG);

  assign req_ready_o = ready_q & ~flush_i;
  assign accept      = req_valid_i & req_ready_o;
  assign busy_o      = (state != S_IDLE);

  // Sign correction of the divider result.
  logic [XLEN-1:0] quo_fix, rem_fix, div_res;

  assign quo_fix = (neg_a_q ^ neg_b_q) ? -div_quo_i : div_quo_i;
  assign rem_fix = neg_a_q ? -div_rem_i : div_rem_i;
  assign div_res = rem_sel_q ? rem_fix : quo_fix;

  // Result cache.
  logic            hit;
  logic [XLEN-1:0] hit_res;

`ifdef DIV_REQ_CACHE_EN
  logic            c_valid, c_sgn;
  logic [XLEN-1:0] c_a, c_b, c_quo, c_rem;
  logic [XLEN-1:0] a_q, b_q;   // original operands of the request in flight
  logic            sgn_q;

  assign hit     = c_valid & (c_a == req_a_i) & (c_b == req_b_i) & (c_sgn == sgn);
  assign hit_res = req_op_i[1] ? c_rem : c_quo;

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the cache payload is reset along with c_valid so the whole
      // block leaves reset all-zero; only c_valid matters functionally.
      c_valid <= 1'b0;
      c_sgn   <= 1'b0;
      c_a     <= '0;
      c_b     <= '0;
      c_quo   <= '0;
      c_rem   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
    end else begin
      // Flush wins over a coincident fill: that result is being discarded.
      if (flush_i || (accept && special)) begin
        c_valid <= 1'b0;
      end else if (state == S_WAIT && div_done_i) begin
        c_valid <= 1'b1;
        c_a     <= a_q;
        c_b     <= b_q;
        c_sgn   <= sgn_q;
        c_quo   <= quo_fix;
        c_rem   <= rem_fix;
      end
      if (accept) begin
        a_q   <= req_a_i;
        b_q   <= req_b_i;
        sgn_q <= sgn;
      end
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register sees the pre-edge values of the others.
      state       <= S_IDLE;
      ready_q     <= 1'b0;
      rem_sel_q   <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      tag_q       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_tag_o   <= '0;
      div_start_o <= 1'b0;
      div_opr1_o  <= '0;
      div_opr2_o  <= '0;
    end else begin
      div_start_o <= 1'b0;
      case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            rem_sel_q  <= req_op_i[1];
            neg_a_q    <= neg_a;
            neg_b_q    <= neg_b;
            tag_q      <= req_tag_i;
            div_opr1_o <= mag_a;
            div_opr2_o <= mag_b;
            ready_q    <= 1'b0;
            if (special || hit) begin
              state       <= S_RESP;
              rsp_valid_o <= 1'b1;
              rsp_data_o  <= special ? special_res : hit_res;
              rsp_tag_o   <= req_tag_i;
            end else begin
              state       <= S_START;
              div_start_o <= 1'b1;
            end
          end
        end

        S_START: begin
          // The start pulse is already out, so a flush must still wait for done.
          state <= flush_i ? S_DRAIN : S_WAIT;
        end

        S_WAIT: begin
          if (flush_i) begin
            if (div_done_i) begin
              state   <= S_IDLE;
              ready_q <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else if (div_done_i) begin
            state       <= S_RESP;
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= div_res;
            rsp_tag_o   <= tag_q;
          end
        end

        S_RESP: begin
          if (flush_i || rsp_ready_i) begin
            state       <= S_IDLE;
            rsp_valid_o <= 1'b0;
            ready_q     <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (div_done_i) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end
        end

        default: begin
          state       <= S_IDLE;
          rsp_valid_o <= 1'b0;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_req_ctrl.sv
// Testbench for div_req_ctrl: a behavioural divider answers start pulses after
// a fixed latency; expected results come from a RISC-V reference function and
// flow through a scoreboard queue popped on each response handshake.
module tb_div_req_ctrl;

  localparam int XLEN    = 32;
  localparam int TAG_W   = 5;
  localparam int DIV_LAT = 4;
`ifdef DIV_REQ_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid_i, req_ready_o;
  logic [1:0]       req_op_i;
  logic [XLEN-1:0]  req_a_i, req_b_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             flush_i;
  logic             rsp_valid_o, rsp_ready_i;
  logic [XLEN-1:0]  rsp_data_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             busy_o, div_start_o;
  logic [XLEN-1:0]  div_opr1_o, div_opr2_o;
  logic             div_done_i;
  logic [XLEN-1:0]  div_quo_i, div_rem_i;

  div_req_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_tag_i   (req_tag_i),
    .flush_i     (flush_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_tag_o   (rsp_tag_o),
    .busy_o      (busy_o),
    .div_start_o (div_start_o),
    .div_opr1_o  (div_opr1_o),
    .div_opr2_o  (div_opr2_o),
    .div_done_i  (div_done_i),
    .div_quo_i   (div_quo_i),
    .div_rem_i   (div_rem_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension reference result.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!op[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic logic [31:0] mag(input logic [1:0] op, input logic [31:0] x);
    return (!op[0] && x[31]) ? (~x + 32'd1) : x;
  endfunction

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_start = 0;
  logic [31:0] last_opr1, last_opr2;

  // Start-pulse counter and response scoreboard.
  always @(negedge clk) begin
    if (div_start_o) begin
      n_start++;
      last_opr1 = div_opr1_o;
      last_opr2 = div_opr2_o;
    end
    if (rst && rsp_valid_o && rsp_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_data", rsp_data_o, mon_e.data);
        check("rsp_tag", {27'd0, rsp_tag_o}, {27'd0, mon_e.tag});
      end
    end
  end

  // Behavioural divider: done DIV_LAT cycles after the start cycle.
  int          dcnt = 0;
  logic [31:0] m_a, m_b;
  initial begin
    div_done_i = 1'b0;
    div_quo_i  = '0;
    div_rem_i  = '0;
    forever begin
      @(negedge clk);
      if (!rst) dcnt = 0;
      else if (div_start_o) begin
        m_a  = div_opr1_o;
        m_b  = div_opr2_o;
        dcnt = DIV_LAT;
      end
      @(posedge clk);
      #1;
      div_done_i = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          div_done_i = 1'b1;
          div_quo_i  = m_a / m_b;
          div_rem_i  = m_a % m_b;
        end
      end
    end
  end

  task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag);
    bit ok = 1'b0;
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_a_i     = a;
    req_b_i     = b;
    req_tag_i   = tag;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  // Full transaction; fast = answered without the divider (special or cache hit).
  task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input bit fast);
    int s0;
    int waits = 0;
    bit ok = 1'b0;
    sb.push_back('{ref_res(op, a, b), tag});
    s0 = n_start;
    drive_req(op, a, b, tag);
    for (int i = 1; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        ok    = 1'b1;
        waits = i;
        break;
      end
    end
    check("rsp_seen", {31'd0, ok}, 32'd1);
    if (fast) begin
      check("fast_latency", waits, 32'd1);
      check("no_start", n_start - s0, 32'd0);
    end else begin
      check("latency", waits, DIV_LAT + 2);
      check("one_start", n_start - s0, 32'd1);
      check("opr1", last_opr1, mag(op, a));
      check("opr2", last_opr2, mag(op, b));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd0);
    check({pfx, "_req_ready"}, {31'd0, req_ready_o}, 32'd0);
    check({pfx, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({pfx, "_start"}, {31'd0, div_start_o}, 32'd0);
    check({pfx, "_rsp_data"}, rsp_data_o, 32'd0);
    check({pfx, "_rsp_tag"}, {27'd0, rsp_tag_o}, 32'd0);
    check({pfx, "_opr1"}, div_opr1_o, 32'd0);
    check({pfx, "_opr2"}, div_opr2_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  s0;
    bit  ok;
    rst         = 1'b0;
    req_valid_i = 1'b0;
    req_op_i    = 2'b00;
    req_a_i     = '0;
    req_b_i     = '0;
    req_tag_i   = '0;
    flush_i     = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Normal divides; same operands with a new op can hit the cache.
    run_req(2'b01, 32'd8, 32'd3, 5'd1, 1'b0);                // DIVU 8/3 = 2
    run_req(2'b11, 32'd8, 32'd3, 5'd2, CACHE);               // REMU 8/3 = 2
    run_req(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b0);        // DIV -7/2 = -3
    run_req(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, CACHE);       // REM -7/2 = -1
    run_req(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd5, 1'b0);        // REM 7/-2 = 1

    // Locally resolved cases.
    run_req(2'b00, 32'd5, 32'd0, 5'd6, 1'b1);                // DIV 5/0
    run_req(2'b11, 32'd5, 32'd0, 5'd7, 1'b1);                // REMU 5/0
    run_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1); // DIV overflow
    run_req(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1); // REM overflow

    // Response back-pressure: output held, nothing new accepted.
    s0 = n_start;
    rsp_ready_i = 1'b0;
    sb.push_back('{32'd3, 5'd10});
    drive_req(2'b01, 32'd20, 32'd6, 5'd10);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("stall_rsp_seen", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    req_op_i    = 2'b01;
    req_a_i     = 32'd1;
    req_b_i     = 32'd1;
    req_tag_i   = 5'd11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("stall_data", rsp_data_o, 32'd3);
      check("stall_tag", {27'd0, rsp_tag_o}, 32'd10);
      check("stall_req_ready", {31'd0, req_ready_o}, 32'd0);
      @(posedge clk);
      #1;
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ready_after_rsp", {31'd0, req_ready_o}, 32'd1);
    check("stall_one_start", n_start - s0, 32'd1);
    @(posedge clk);
    #1;

    // Flush during WAIT: drained silently, ready only after the divider is done.
    s0 = n_start;
    drive_req(2'b01, 32'd50, 32'd5, 5'd12);
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("drain_ready", {31'd0, req_ready_o}, 32'd0);
      if (div_done_i) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_done_seen", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ready_after_drain", {31'd0, req_ready_o}, 32'd1);
    check("drain_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    check("drain_one_start", n_start - s0, 32'd1);
    @(posedge clk);
    #1;
    run_req(2'b00, 32'hFFFF_FF9C, 32'd10, 5'd13, 1'b0);      // DIV -100/10 = -10

    // Reset in the middle of WAIT.
    drive_req(2'b01, 32'd9, 32'd4, 5'd14);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero_outputs("midreset");
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_req(2'b01, 32'd9, 32'd4, 5'd15, 1'b0);               // DIVU 9/4 = 2

    // Repeat operands: cache hit only when the cache is built in.
    run_req(2'b00, 32'd100, 32'd7, 5'd16, 1'b0);             // DIV 100/7 = 14
    run_req(2'b10, 32'd100, 32'd7, 5'd17, CACHE);            // REM 100/7 = 2

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
